// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, stop bit(s), with a one-word
// holding register so consecutive frames leave no idle gap on the line.
module uart_tx #(
  parameter int DATA_BITS      = 8,
  parameter int CYCLES_PER_BIT = 108,
  parameter int STOP_BITS      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data_w,
  input  logic                 i_data_valid_w,
  output logic                 o_ready,
  output logic                 o_tx_w,
  output logic                 o_busy
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] BAUD_MAX  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q, tx_d;
  logic                 ready_q;
  logic                 busy_q;
  logic                 accept;
  logic                 bit_end;
  logic                 frame_done;

  assign accept  = i_data_valid_w && ready_q;
  assign bit_end = (baud_q == '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    frame_done  = 1'b0;

    if (state_q != IDLE) baud_d = baud_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = i_data_w;
          state_d = START;
          baud_d  = BAUD_MAX;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          baud_d  = BAUD_MAX;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = BAUD_MAX;
          if (idx_q == LAST_DATA) begin
            state_d = STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = BAUD_MAX;
          if (idx_q == LAST_STOP) frame_done = 1'b1;
          else                    idx_d      = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The held word wins at frame end; a fresh accept can only land there
    // when the holding register is empty, so nothing is lost or duplicated.
    if (frame_done) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        state_d     = START;
        tx_d        = 1'b0;
      end else if (accept) begin
        shift_d = i_data_w;
        state_d = START;
        tx_d    = 1'b0;
      end else begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    end else if (accept && state_q != IDLE) begin
      hold_d      = i_data_w;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!i_rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      ready_q     <= ~hold_full_d;
      busy_q      <= (state_d != IDLE) || hold_full_d;
    end
  end

  assign o_tx_w  = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one and two stop-bit instances driven by the same
// producer, compared every cycle against a frame-offset model of the line.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_data_w;
  logic       i_data_valid_w;
  logic       tx0, ready0, busy0;
  logic       tx1, ready1, busy1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  uart_tx #(.DATA_BITS(DB), .CYCLES_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_w(i_data_w),
    .i_data_valid_w(i_data_valid_w), .o_ready(ready0), .o_tx_w(tx0), .o_busy(busy0)
  );

  uart_tx #(.DATA_BITS(DB), .CYCLES_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_w(i_data_w),
    .i_data_valid_w(i_data_valid_w), .o_ready(ready1), .o_tx_w(tx1), .o_busy(busy1)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a word plus the cycle offset since its start
  // bit began; the line level follows from offset / CPB.
  logic       m_active[2] = '{1'b0, 1'b0};
  logic [7:0] m_word[2]   = '{8'h00, 8'h00};
  int         m_off[2]    = '{0, 0};
  logic       m_held[2]   = '{1'b0, 1'b0};
  logic [7:0] m_hword[2]  = '{8'h00, 8'h00};

  function automatic int frame_len(input int inst);
    return (1 + DB + 1 + inst) * CPB;
  endfunction

  function automatic logic line_at(input logic [7:0] w, input int off);
    int b;
    logic [7:0] ww;
    b  = off / CPB;
    ww = w;
    if (b == 0) return 1'b0;
    if (b <= DB) return ww[b-1];
    return 1'b1;
  endfunction

  function automatic logic exp_tx(input int inst);
    return m_active[inst] ? line_at(m_word[inst], m_off[inst]) : 1'b1;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_off[i]    <= 0;
        m_held[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_active[i]) begin
          if (m_off[i] + 1 == frame_len(i)) begin
            m_off[i] <= 0;
            if (m_held[i]) begin
              m_word[i] <= m_hword[i];
              m_held[i] <= 1'b0;
            end else if (i_data_valid_w) begin
              m_word[i] <= i_data_w;
            end else begin
              m_active[i] <= 1'b0;
            end
          end else begin
            m_off[i] <= m_off[i] + 1;
            if (i_data_valid_w && !m_held[i]) begin
              m_held[i]  <= 1'b1;
              m_hword[i] <= i_data_w;
            end
          end
        end else if (i_data_valid_w) begin
          m_active[i] <= 1'b1;
          m_word[i]   <= i_data_w;
          m_off[i]    <= 0;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("tx0", tx0, exp_tx(0));
      check("ready0", ready0, !m_held[0]);
      check("busy0", busy0, m_active[0] || m_held[0]);
      check("tx1", tx1, exp_tx(1));
      check("ready1", ready1, !m_held[1]);
      check("busy1", busy1, m_active[1] || m_held[1]);
    end
  end

  // Called at a negedge; returns at the negedge after the word is taken.
  task automatic offer(input logic [7:0] d);
    bit rdy;
    int n;
    n = 0;
    i_data_valid_w = 1'b1;
    i_data_w       = d;
    do begin
      rdy = !m_held[0];
      @(negedge i_clk);
      n++;
    end while (!rdy && n < 500);
    check("accept", rdy, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 400; k++) begin
      idle = !m_active[0] && !m_held[0] && !m_active[1] && !m_held[1];
      if (idle) break;
      @(negedge i_clk);
    end
    check("idle_reached", idle, 1);
  endtask

  initial begin
    int n0, n1;
    i_rst_n        = 1'b0;
    i_data_valid_w = 1'b0;
    i_data_w       = 8'h00;
    repeat (3) @(negedge i_clk);
    check("rst_tx0", tx0, 1);
    check("rst_ready0", ready0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_tx1", tx1, 1);
    check("rst_ready1", ready1, 1);
    check("rst_busy1", busy1, 0);
    i_rst_n = 1'b1;
    chk_en  = 1;
    repeat (2) @(negedge i_clk);

    // Single word: busy length is the frame length of each instance.
    offer(8'hA5);
    i_data_valid_w = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 200; k++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (!busy0 && !busy1) break;
      @(negedge i_clk);
    end
    check("busy_len_1stop", n0, 40);
    check("busy_len_2stop", n1, 44);
    wait_idle();

    // Back-to-back: second word goes to holding on the next cycle.
    offer(8'h55);
    offer(8'h0F);
    i_data_valid_w = 1'b0;
    check("b2b_ready_low", ready0, 0);
    wait_idle();

    // Valid held across several frames.
    i_data_valid_w = 1'b1;
    i_data_w       = 8'h3C;
    repeat (120) @(negedge i_clk);
    i_data_valid_w = 1'b0;
    wait_idle();

    // Reset in the middle of data bit 3.
    offer(8'hF0);
    i_data_valid_w = 1'b0;
    repeat (17) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_tx0", tx0, 1);
    check("midrst_busy0", busy0, 0);
    check("midrst_ready0", ready0, 1);
    check("midrst_tx1", tx1, 1);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (12) @(negedge i_clk);
    check("post_rst_tx0", tx0, 1);
    check("post_rst_busy0", busy0, 0);

    // Randomised producer traffic, including accepts at frame end.
    for (int k = 0; k < 900; k++) begin
      i_data_valid_w = (k % 300 < 150) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0);
      i_data_w       = 8'($urandom);
      @(negedge i_clk);
    end
    i_data_valid_w = 1'b0;
    wait_idle();
    repeat (4) @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
